// File: rtl/csu_sequencer.sv
// Power sequencer and segment decoder for the current-source-unit array.
// Handles bias power-up, test-bus gating and DWA rotation of the unary segments.
module csu_sequencer #(
   parameter int PUP_WAIT = 64,
   parameter int DWA_EN   = 1
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        enable,
   input  logic [1:0]  atb_sel,
   input  logic [10:0] code,
   input  logic        code_valid,
   output logic        code_ready,
   input  logic        lsb_red_sel,
   output logic        pdb,
   output logic [1:0]  atb_ena,
   output logic [16:0] them_en,
   output logic [5:0]  bin_en,
   output logic        bin0_red_en,
   output logic        sat,
   output logic        running
);

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      BIAS_UP = 2'd1,
      RUN     = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   localparam logic [9:0]  PUP_LAST  = 10'(PUP_WAIT - 1);
   localparam logic [10:0] CODE_MAX  = 11'd1151;
   localparam logic [4:0]  N_UNITS   = 5'd17;

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [4:0]  ptr_q, ptr_d;
   logic        pdb_q, pdb_d;
   logic [1:0]  atb_ena_q, atb_ena_d;
   logic [16:0] them_en_q, them_en_d;
   logic [5:0]  bin_en_q, bin_en_d;
   logic        red_q, red_d;
   logic        sat_q, sat_d;

   logic        xfer_s;
   logic        clamp_s;
   logic [4:0]  n_s;
   logic [5:0]  bin_s;
   logic [16:0] mask_s;
   logic [5:0]  ptr_sum_s;

   // Rotated window of n enabled units starting at ptr, wrapping at 17.
   function automatic logic [16:0] dwa_mask(input logic [4:0] ptr, input logic [4:0] n);
      logic [16:0] m;
      logic [5:0]  off;
      m = 17'd0;
      for (int i = 0; i < 17; i++) begin
         if (6'(i) >= {1'b0, ptr}) begin
            off = 6'(i) - {1'b0, ptr};
         end else begin
            off = 6'(i) + 6'd17 - {1'b0, ptr};
         end
         m[i] = (off < {1'b0, n});
      end
      return m;
   endfunction

   // Thermometer mask anchored at index 0.
   function automatic logic [16:0] fixed_mask(input logic [4:0] n);
      logic [16:0] m;
      m = 17'd0;
      for (int i = 0; i < 17; i++) begin
         m[i] = (5'(i) < n);
      end
      return m;
   endfunction

   assign code_ready  = (state_q == RUN) && enable;
   assign running     = (state_q == RUN);
   assign xfer_s      = code_valid && code_ready;
   assign pdb         = pdb_q;
   assign atb_ena     = atb_ena_q;
   assign them_en     = them_en_q;
   assign bin_en      = bin_en_q;
   assign bin0_red_en = red_q;
   assign sat         = sat_q;

   // State sequencing and bias-settle counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = 10'd0;
      case (state_q)
         OFF: begin
            if (enable) begin
               state_d = BIAS_UP;
            end else begin
               state_d = OFF;
            end
         end
         BIAS_UP: begin
            if (!enable) begin
               state_d = DRAIN;
            end else if (cnt_q == PUP_LAST) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = DRAIN;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            state_d = OFF;
         end
         default: begin
            state_d = OFF;
         end
      endcase
   end

   // Code decode: out-of-range codes saturate to full scale.
   always_comb begin
      clamp_s = (code > CODE_MAX);
      if (clamp_s) begin
         n_s   = N_UNITS;
         bin_s = 6'h3F;
      end else if (code[10:6] > N_UNITS) begin
         n_s   = N_UNITS;
         bin_s = code[5:0];
      end else begin
         n_s   = code[10:6];
         bin_s = code[5:0];
      end
      if (DWA_EN != 0) begin
         mask_s = dwa_mask(ptr_q, n_s);
      end else begin
         mask_s = fixed_mask(n_s);
      end
      ptr_sum_s = {1'b0, ptr_q} + {1'b0, n_s};
   end

   // Next values of the registered array controls.
   always_comb begin
      ptr_d     = ptr_q;
      them_en_d = them_en_q;
      bin_en_d  = bin_en_q;
      red_d     = red_q;
      sat_d     = 1'b0;
      pdb_d     = (state_d != OFF);
      if ((state_d == BIAS_UP) || (state_d == RUN)) begin
         atb_ena_d = atb_sel;
      end else begin
         atb_ena_d = 2'b00;
      end
      if (state_d != RUN) begin
         them_en_d = 17'd0;
         bin_en_d  = 6'd0;
         red_d     = 1'b0;
         if (state_d == OFF) begin
            ptr_d = 5'd0;
         end else begin
            ptr_d = ptr_q;
         end
      end else if (xfer_s) begin
         them_en_d = mask_s;
         bin_en_d  = {bin_s[5:1], (lsb_red_sel ? 1'b0 : bin_s[0])};
         red_d     = lsb_red_sel & bin_s[0];
         sat_d     = clamp_s;
         if (DWA_EN == 0) begin
            ptr_d = 5'd0;
         end else if (ptr_sum_s >= 6'd17) begin
            ptr_d = 5'(ptr_sum_s - 6'd17);
         end else begin
            ptr_d = ptr_sum_s[4:0];
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // State and output registers; reset forces everything off without draining.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= OFF;
         cnt_q     <= 10'd0;
         ptr_q     <= 5'd0;
         pdb_q     <= 1'b0;
         atb_ena_q <= 2'b00;
         them_en_q <= 17'd0;
         bin_en_q  <= 6'd0;
         red_q     <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         pdb_q     <= pdb_d;
         atb_ena_q <= atb_ena_d;
         them_en_q <= them_en_d;
         bin_en_q  <= bin_en_d;
         red_q     <= red_d;
         sat_q     <= sat_d;
      end
   end

endmodule

// File: doc/csu_sequencer.md
# csu_sequencer

Digital controller for the current-source-unit array: owns its power-down, test-bus enable and segment switching. It power-sequences the array's bias (`pdb`) and accepts DAC codes over a valid/ready handshake. Each code is split into 17 unary segments plus 6 binary bits. The unary segments are selected with data-weighted-averaging (DWA) rotation to spread mismatch. The block drives `pdb`, `atb_ena` and every per-unit switch enable of the analog array.

## Interface
Parameters:
- `PUP_WAIT`, 64: cycles from `pdb` rising to the first accepted code (bias settle); legal range 1..1023.
- `DWA_EN`, 1: 1 = rotating unary selection; 0 = fixed selection from index 0 upward.

Ports:
- Clock and reset: one clock (`clk`); reset (`rstb`) is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rstb`  in  1  asynchronous active-low reset.
- `enable`  in  1  level request to power the array and run.
- `atb_sel`  in  2  requested test-bus enable.
- `code`  in  11  DAC code: [10:6] unary count, [5:0] binary.
- `code_valid`  in  1  code present.
- `code_ready`  out  1  block accepts code; combinational, `(state==RUN) && enable`.
- `lsb_red_sel`  in  1  0 = LSB on `bin_en[0]`; 1 = LSB on redundant unit `bin0_red_en`.
- `pdb`  out  1  array power-down bar.
- `atb_ena`  out  2  array test-bus enable.
- `them_en`  out  17  unary segment enables; bit i drives `Iout_them_i`.
- `bin_en`  out  6  binary unit enables; bit i drives `Iout_binary_i`.
- `bin0_red_en`  out  1  redundant LSB unit enable.
- `sat`  out  1  one-cycle pulse: the last applied code was clamped.
- `running`  out  1  state==RUN.

## Operation
- FSM states: OFF, BIAS_UP, RUN, DRAIN.
  - OFF -> BIAS_UP when `enable`=1.
  - BIAS_UP -> RUN after PUP_WAIT cycles in BIAS_UP.
  - BIAS_UP or RUN -> DRAIN when `enable`=0; this takes priority over the BIAS_UP -> RUN transition.
  - DRAIN -> OFF unconditionally after 1 cycle.
- `pdb` is 1 in BIAS_UP, RUN and DRAIN; it is 0 in OFF.
- `atb_ena` is the registered `atb_sel` in BIAS_UP and RUN; it is forced to 00 in OFF and DRAIN.
- Unary and binary enables are all 0 except in RUN, and they are cleared at the edge entering DRAIN.
- Code transfer occurs when `code_valid && code_ready`. Codes presented while `code_ready`=0 are not consumed and have no effect.
- Code decode:
  - If `code` > 1151 (17·64+63), the code is clamped: n=17, binary=6'h3F, and `sat` pulses.
  - Otherwise n=`code[10:6]`, clamped to 17, and binary=`code[5:0]`.
- Binary mapping:
  - `bin_en[5:1]` = binary[5:1].
  - `lsb_red_sel` is sampled with the code. If 0: `bin_en[0]`=binary[0] and `bin0_red_en`=0. If 1: `bin0_red_en`=binary[0] and `bin_en[0]`=0.
- Unary selection with DWA_EN=1:
  - Enable indices ptr, ptr+1, ..., ptr+n-1, all taken mod 17.
  - Update ptr <= (ptr+n) mod 17.
  - n=0 enables none and leaves ptr unchanged; n=17 enables all and leaves ptr unchanged.
- Unary selection with DWA_EN=0: `them_en[i]` = (i<n); ptr stays 0.
- ptr is a 5-bit register, range 0..16. It resets to 0 and is cleared to 0 on entering OFF. It holds its value while RUN has no transfer.
- Outputs hold their last applied code until the next transfer or DRAIN.

## Timing
- Reset values:
  - State OFF, ptr=0, registered `atb_sel`=00.
  - `pdb`=0, `atb_ena`=00, `them_en`=0, `bin_en`=0, `bin0_red_en`=0, `sat`=0, `running`=0, `code_ready`=0.
- Reset mid-operation: all outputs take their reset values asynchronously; there is no draining.
- `pdb` rises at the edge after `enable` is first sampled 1 in OFF.
- `code_ready` rises exactly PUP_WAIT cycles after `pdb` rises, provided `enable` stays 1.
- Code latency: a code transferred at edge k appears on `them_en`/`bin_en` and `sat` immediately after edge k (registered outputs, 1 cycle).
- Back-to-back transfers are allowed: one code per cycle, and ptr advances every transfer.
- Power-down: `enable`=0 sampled at edge k → enables and `atb_ena` are 0 after edge k, and `pdb` falls after edge k+1.
- A code presented in the cycle `enable` drops is not accepted, because `code_ready`=0.
- `enable` re-asserted during DRAIN: the block still passes through OFF for 1 cycle before entering BIAS_UP.
- `atb_sel` is registered every cycle; `atb_ena` follows 1 cycle later, subject to the state gating above.

## Test plan
- Power-up, PUP_WAIT=4: `enable` 0→1 → `pdb`=1 one edge later; `code_ready`=1 exactly 4 cycles after that; all enables stay 0 until the first transfer.
- DWA rotation:
  - Code 197 (n=3, bin 5) → `them_en`=0x00007, `bin_en`=000101, ptr=3.
  - Then code 1024 (n=16) → `them_en`=0x1FFFB, `bin_en`=0, ptr=2.
  - Then code 1088 (n=17) → `them_en`=0x1FFFF, ptr=2.
- Saturation: code 2047 → `them_en`=0x1FFFF, `bin_en`=0x3F, `sat`=1 for one cycle. The following code 64 gives `sat`=0 and `them_en` with only bit ptr set.
- Power-down mid-run: `enable`→0 at edge k while `code_valid`=1 → no transfer; enables and `atb_ena` are 0 after edge k; `pdb`=0 after k+1. Re-enable repeats the full PUP_WAIT delay and restarts from ptr=0.
- Test bus: `atb_sel`=10 in OFF → `atb_ena`=00. After power-up → `atb_ena`=10. Changing to 11 → `atb_ena`=11 one cycle later.
- DWA_EN=0 with redundant LSB: code 3*64+1 with `lsb_red_sel`=1 → `them_en`=0x00007 on every repeat, `bin_en`=0, `bin0_red_en`=1. Asserting `rstb`=0 asynchronously clears all outputs.
